// File: rtl/nanci_pkg.sv
// ---------------------------------------------------------------------------
// nanci_pkg
// Shared definitions for the Nanci mesh sorter processing elements:
//   - instruction word layout {op[1:0], dir[1:0]} and its width
//   - opcode constants  OP_NOP / OP_S / OP_MIN / OP_MAX
//   - direction constants DIR_L / DIR_R / DIR_U / DIR_D
//   - key_of(): extracts the key field (low bits) of a record
// ---------------------------------------------------------------------------
package nanci_pkg;

  localparam int unsigned INSTR_W   = 4;
  localparam int unsigned REC_MAX_W = 32;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_S   = 2'b01;
  localparam logic [1:0] OP_MIN = 2'b10;
  localparam logic [1:0] OP_MAX = 2'b11;

  localparam logic [1:0] DIR_L = 2'b00;
  localparam logic [1:0] DIR_R = 2'b01;
  localparam logic [1:0] DIR_U = 2'b10;
  localparam logic [1:0] DIR_D = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] dir;
  } instr_t;

  // Records are zero-extended to REC_MAX_W bits by the caller; the key is the
  // low dw bits, so masking off the tag leaves a directly comparable value.
  function automatic logic [REC_MAX_W-1:0] key_of(input logic [REC_MAX_W-1:0] rec,
                                                  input int unsigned dw);
    logic [REC_MAX_W-1:0] mask;
    mask = (32'd1 << dw) - 32'd1;
    return rec & mask;
  endfunction

endpackage

// File: rtl/pe_sequencer.sv
// ---------------------------------------------------------------------------
// pe_sequencer
// Program ROM plus program counter, pass counter and halt flag for one PE.
// The ROM is built from PROG_INIT (word k in bits [4k+3:4k], zero = NOP).
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (pc, pass, halted -> 0)
//   o_instr  out  instruction to execute this cycle (NOP once halted)
// ---------------------------------------------------------------------------
module pe_sequencer
  import nanci_pkg::*;
#(
  parameter string FILENAME    = "",
  parameter int    PROG_DEPTH  = 16,
  parameter int    SORT_CYCLES = 1,
  parameter logic [PROG_DEPTH*INSTR_W-1:0] PROG_INIT = '0
) (
  input  logic   clk,
  input  logic   rst,
  output instr_t o_instr
);

  localparam int PC_W   = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
  localparam int PASS_W = (SORT_CYCLES > 0) ? $clog2(SORT_CYCLES + 1) : 1;
  localparam logic [PC_W-1:0]   PC_LAST    = PC_W'(PROG_DEPTH - 1);
  localparam logic [PASS_W-1:0] PASS_FINAL = PASS_W'(SORT_CYCLES);

  logic [INSTR_W-1:0] rom [PROG_DEPTH];

  logic [PC_W-1:0]   pc_q,   pc_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              halted_q, halted_d;
  logic [PASS_W-1:0] pass_nxt;

  // ROM contents are fixed at elaboration from the parameter image.
  initial begin
    for (int k = 0; k < PROG_DEPTH; k++) begin
      rom[k] = PROG_INIT[k*INSTR_W +: INSTR_W];
    end
  end

  // Next-state for pc / pass / halted; the final word of the last pass still
  // executes, and the halt takes effect on the same edge as the wrap.
  always_comb begin
    pc_d     = pc_q;
    pass_d   = pass_q;
    halted_d = halted_q;
    pass_nxt = pass_q + PASS_W'(1);
    if (halted_q) begin
      pc_d     = pc_q;
      pass_d   = pass_q;
      halted_d = 1'b1;
    end else if (pc_q == PC_LAST) begin
      pc_d     = '0;
      pass_d   = pass_nxt;
      halted_d = (pass_nxt >= PASS_FINAL);
    end else begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      pass_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pass_q   <= pass_d;
      halted_q <= halted_d;
    end
  end

  // Instruction fetch; a halted PE sees only NOPs.
  always_comb begin
    if (halted_q) begin
      o_instr = '{op: OP_NOP, dir: DIR_L};
    end else begin
      o_instr = instr_t'(rom[pc_q]);
    end
  end

endmodule

// File: rtl/mesh_sort_pe.sv
// ---------------------------------------------------------------------------
// mesh_sort_pe
// One processing element of the Nanci mesh sorter. Holds a record {tag, key}
// and executes a fixed program of load / compare-exchange steps against its
// four mesh neighbours, one instruction per cycle.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   rst_memory   in   tag loaded into the record at reset (key = I)
//   i_PE_l/r/u/d in   neighbour records {tag, key}
//   o_PE         out  own record, straight from the flop
// ---------------------------------------------------------------------------
module mesh_sort_pe
  import nanci_pkg::*;
#(
  parameter int    N            = 1,
  parameter int    I            = 0,
  parameter string FILENAME     = "",
  parameter int    ADDR_WIDTH   = 3,
  parameter int    DATA_WIDTH   = 3,
  parameter int    SORT_CYCLES  = 1,
  parameter int    FIRST_IN_ROW = 0,
  parameter int    PROG_DEPTH   = 16,
  parameter logic [PROG_DEPTH*INSTR_W-1:0] PROG_INIT = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          rst_memory,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_l,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_r,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_u,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_d,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE
);

  localparam int REC_W = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] RST_KEY = DATA_WIDTH'(I);

  if ((N < 1) || (I < 0) || (I >= N * N)) begin : g_bad_index
    $error("mesh_sort_pe: PE index I outside 0..N*N-1");
  end

  instr_t                 instr_s;
  logic [REC_W-1:0]       nbr_s;
  logic                   nbr_absent_s;
  logic [REC_MAX_W-1:0]   nbr_key_s;
  logic [REC_MAX_W-1:0]   own_key_s;
  logic [REC_W-1:0]       rec_q, rec_d;

  pe_sequencer #(
    .FILENAME    (FILENAME),
    .PROG_DEPTH  (PROG_DEPTH),
    .SORT_CYCLES (SORT_CYCLES),
    .PROG_INIT   (PROG_INIT)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .o_instr (instr_s)
  );

  // Neighbour select; a column-0 PE has no left neighbour at all.
  always_comb begin
    case (instr_s.dir)
      DIR_L:   nbr_s = i_PE_l;
      DIR_R:   nbr_s = i_PE_r;
      DIR_U:   nbr_s = i_PE_u;
      DIR_D:   nbr_s = i_PE_d;
      default: nbr_s = i_PE_l;
    endcase
    if ((FIRST_IN_ROW != 0) && (instr_s.dir == DIR_L)) begin
      nbr_absent_s = 1'b1;
    end else begin
      nbr_absent_s = 1'b0;
    end
  end

  // Execute: load or compare-exchange; strict compares so ties keep our own record.
  always_comb begin
    rec_d     = rec_q;
    nbr_key_s = key_of(REC_MAX_W'(nbr_s), DATA_WIDTH);
    own_key_s = key_of(REC_MAX_W'(rec_q), DATA_WIDTH);
    if (nbr_absent_s) begin
      rec_d = rec_q;
    end else begin
      case (instr_s.op)
        OP_NOP: rec_d = rec_q;
        OP_S:   rec_d = nbr_s;
        OP_MIN: begin
          if (nbr_key_s < own_key_s) begin
            rec_d = nbr_s;
          end else begin
            rec_d = rec_q;
          end
        end
        OP_MAX: begin
          if (nbr_key_s > own_key_s) begin
            rec_d = nbr_s;
          end else begin
            rec_d = rec_q;
          end
        end
        default: rec_d = rec_q;
      endcase
    end
  end

  // Record register; reset wins over any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rec_q <= {rst_memory, RST_KEY};
    end else begin
      rec_q <= rec_d;
    end
  end

  assign o_PE = rec_q;

endmodule

// File: tb/tb_mesh_sort_pe.sv
// ---------------------------------------------------------------------------
// tb_mesh_sort_pe
// Several PEs with different programs/parameters share clock, reset and
// neighbour inputs. A per-PE behavioural model (edge count since reset ->
// program word, applied with plain arithmetic) predicts every record every
// cycle; directed constants pin down the specific scenarios.
// ---------------------------------------------------------------------------
module tb_mesh_sort_pe;

  localparam int NDUT = 7;

  // Programs: word k at bits [4k+3:4k]; op[3:2] dir[1:0].
  localparam logic [63:0] PROG_SU   = 64'h0000_0000_0000_0006; // S u
  localparam logic [63:0] PROG_SL   = 64'h0000_0000_0000_0004; // S l
  localparam logic [63:0] PROG_MINU = 64'h0000_0000_0000_000A; // MIN u
  localparam logic [63:0] PROG_MAXD = 64'h0000_0000_0000_000F; // MAX d
  localparam logic [63:0] PROG_SR   = 64'h0000_0000_0000_0005; // S r
  // MIN u, MAX d, S r, NOP, MAX l, MIN r, S d, MIN l  (depth 8)
  localparam logic [31:0] PROG_MIX  = 32'h879C_05FA;

  logic       clk;
  logic       rst;
  logic [2:0] rst_memory;
  logic [5:0] i_l, i_r, i_u, i_d;
  logic [5:0] o_pe [NDUT];

  // Reference-model configuration per DUT.
  logic [63:0] prog_bits [NDUT];
  int          depth     [NDUT];
  int          sc        [NDUT];
  bit          fir       [NDUT];
  int          ival      [NDUT];

  logic [5:0]  mrec [NDUT];
  int          mcnt;
  int          total_checks;
  int          passed_checks;

  mesh_sort_pe #(.N(3), .I(0), .SORT_CYCLES(1), .FIRST_IN_ROW(0), .PROG_INIT(PROG_SU)) u_d0 (
    .clk(clk), .rst(rst), .rst_memory(rst_memory),
    .i_PE_l(i_l), .i_PE_r(i_r), .i_PE_u(i_u), .i_PE_d(i_d), .o_PE(o_pe[0]));
  mesh_sort_pe #(.N(3), .I(0), .SORT_CYCLES(1), .FIRST_IN_ROW(0), .PROG_INIT(PROG_SL)) u_d1 (
    .clk(clk), .rst(rst), .rst_memory(rst_memory),
    .i_PE_l(i_l), .i_PE_r(i_r), .i_PE_u(i_u), .i_PE_d(i_d), .o_PE(o_pe[1]));
  mesh_sort_pe #(.N(3), .I(0), .SORT_CYCLES(1), .FIRST_IN_ROW(1), .PROG_INIT(PROG_SL)) u_d2 (
    .clk(clk), .rst(rst), .rst_memory(rst_memory),
    .i_PE_l(i_l), .i_PE_r(i_r), .i_PE_u(i_u), .i_PE_d(i_d), .o_PE(o_pe[2]));
  mesh_sort_pe #(.N(3), .I(5), .SORT_CYCLES(1), .FIRST_IN_ROW(0), .PROG_INIT(PROG_MINU)) u_d3 (
    .clk(clk), .rst(rst), .rst_memory(rst_memory),
    .i_PE_l(i_l), .i_PE_r(i_r), .i_PE_u(i_u), .i_PE_d(i_d), .o_PE(o_pe[3]));
  mesh_sort_pe #(.N(3), .I(2), .SORT_CYCLES(1), .FIRST_IN_ROW(0), .PROG_INIT(PROG_MAXD)) u_d4 (
    .clk(clk), .rst(rst), .rst_memory(rst_memory),
    .i_PE_l(i_l), .i_PE_r(i_r), .i_PE_u(i_u), .i_PE_d(i_d), .o_PE(o_pe[4]));
  mesh_sort_pe #(.N(3), .I(0), .SORT_CYCLES(2), .FIRST_IN_ROW(0), .PROG_INIT(PROG_SR)) u_d5 (
    .clk(clk), .rst(rst), .rst_memory(rst_memory),
    .i_PE_l(i_l), .i_PE_r(i_r), .i_PE_u(i_u), .i_PE_d(i_d), .o_PE(o_pe[5]));
  mesh_sort_pe #(.N(3), .I(6), .SORT_CYCLES(3), .FIRST_IN_ROW(1), .PROG_DEPTH(8),
                 .PROG_INIT(PROG_MIX)) u_d6 (
    .clk(clk), .rst(rst), .rst_memory(rst_memory),
    .i_PE_l(i_l), .i_PE_r(i_r), .i_PE_u(i_u), .i_PE_d(i_d), .o_PE(o_pe[6]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction applied to a record, straight from the operation rules.
  function automatic logic [5:0] model_apply(input logic [3:0] ins, input bit no_left,
                                             input logic [5:0] rec, input logic [5:0] l,
                                             input logic [5:0] r, input logic [5:0] u,
                                             input logic [5:0] d);
    int         op;
    int         dir;
    logic [5:0] nbr;
    op  = int'(ins) / 4;
    dir = int'(ins) % 4;
    nbr = (dir == 0) ? l : (dir == 1) ? r : (dir == 2) ? u : d;
    if (no_left && dir == 0) return rec;
    if (op == 1) return nbr;
    if (op == 2) return (int'(nbr) % 8 < int'(rec) % 8) ? nbr : rec;
    if (op == 3) return (int'(nbr) % 8 > int'(rec) % 8) ? nbr : rec;
    return rec;
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // One clock: advance the model on the edge, compare every DUT just after it.
  task automatic step();
    logic [3:0] ins;
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        mrec[k] = {rst_memory, 3'(ival[k])};
      end else if (mcnt < sc[k] * depth[k]) begin
        ins     = prog_bits[k][4*(mcnt % depth[k]) +: 4];
        mrec[k] = model_apply(ins, fir[k], mrec[k], i_l, i_r, i_u, i_d);
      end else begin
        mrec[k] = mrec[k];
      end
    end
    if (rst) mcnt = 0;
    else     mcnt = mcnt + 1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("model_dut%0d_cyc%0d", k, mcnt), o_pe[k], mrec[k]);
    end
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    mcnt          = 0;
    prog_bits = '{PROG_SU, PROG_SL, PROG_SL, PROG_MINU, PROG_MAXD, PROG_SR, {32'h0, PROG_MIX}};
    depth     = '{16, 16, 16, 16, 16, 16, 8};
    sc        = '{1, 1, 1, 1, 1, 2, 3};
    fir       = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    ival      = '{0, 0, 0, 5, 2, 0, 6};
    for (int k = 0; k < NDUT; k++) mrec[k] = 6'b0;

    // Load / neighbour selection.
    rst = 1'b1; rst_memory = 3'b000;
    i_l = 6'b000_001; i_r = 6'b000_010; i_u = 6'b000_011; i_d = 6'b000_100;
    repeat (2) step();
    check("reset_su",   o_pe[0], 6'b000_000);
    check("reset_minu", o_pe[3], 6'b000_101);
    check("reset_maxd", o_pe[4], 6'b000_010);
    rst = 1'b0;
    repeat (4) step();
    check("s_u",         o_pe[0], 6'b000_011);
    check("s_l",         o_pe[1], 6'b000_001);
    check("s_l_no_left", o_pe[2], 6'b000_000);

    // MIN / MAX taking the neighbour.
    rst = 1'b1; i_u = 6'b010_011; i_d = 6'b001_110;
    repeat (2) step();
    rst = 1'b0;
    step();
    check("min_takes", o_pe[3], 6'b010_011);
    check("max_takes", o_pe[4], 6'b001_110);

    // MIN tie and MAX with a smaller neighbour both keep their own record.
    rst = 1'b1; i_u = 6'b010_101; i_d = 6'b001_001;
    repeat (2) step();
    rst = 1'b0;
    step();
    check("min_tie_holds", o_pe[3], 6'b000_101);
    check("max_holds",     o_pe[4], 6'b000_010);

    // Two passes: second load sees the new value, nothing changes after halt.
    rst = 1'b1; i_r = 6'b011_010;
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();
    check("pass1_load", o_pe[5], 6'b011_010);
    i_r = 6'b101_111;
    repeat (8) step();
    check("pass2_load", o_pe[5], 6'b101_111);
    i_r = 6'b110_001;
    repeat (40) step();
    check("halted_holds", o_pe[5], 6'b101_111);

    // Reset in mid-program, then word 0 runs again.
    rst_memory = 3'b110; i_u = 6'b001_100;
    rst = 1'b1; repeat (2) step(); rst = 1'b0;
    repeat (5) step();
    i_u = 6'b111_011;
    rst = 1'b1;
    step();
    check("midreset_rec",  o_pe[0], 6'b110_000);
    check("midreset_min",  o_pe[3], 6'b110_101);
    rst = 1'b0;
    step();
    check("rerun_word0", o_pe[0], 6'b111_011);

    // Randomised traffic with sporadic resets and reset tags.
    for (int n = 0; n < 300; n++) begin
      i_l = 6'($urandom); i_r = 6'($urandom);
      i_u = 6'($urandom); i_d = 6'($urandom);
      rst_memory = 3'($urandom);
      rst = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
